uart_rx_sipo: RTL and testbench
===============================

UART_RX_SIPO -- requirements
Module: uart_rx_sipo

Interface
REQ-001 Parameter OVERSAMPLE, default 16, sets the number of sample_tick pulses per bit period; it SHALL be even and at least 4.
REQ-002 Parameter FRAME_BITS, default 11, sets the frame length: start, 8 data, parity, stop.
REQ-003 clock  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_in  input  1  asynchronous serial line, idle high, LSB first.
REQ-006 sample_tick  input  1  one-clock enable pulse at OVERSAMPLE x baud rate, from the baud generator.
REQ-007 rx_en  input  1  receiver enable; while low the block SHALL stay idle.
REQ-008 data_parll  output  FRAME_BITS  last complete frame: [0]=start, [8:1]=data, [9]=parity, [10]=stop; this is the DeFrame stage input.
REQ-009 frame_done  output  1  one-clock pulse marking a new data_parll value.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 rx_in SHALL pass through a 2-flop synchronizer (rx_s); no logic SHALL use raw rx_in.
REQ-012 FSM states SHALL be IDLE, START, DATA; all counters advance only on cycles with sample_tick=1.
REQ-013 IDLE: on sample_tick with rx_s=0 and rx_en=1, clear tick_cnt and go to START.
REQ-014 START: increment tick_cnt per tick; on the tick where tick_cnt=OVERSAMPLE/2-1, sample rx_s.
REQ-015 START sample =1 (glitch): go to IDLE with no shift and no frame_done.
REQ-016 START sample =0: shift it in, set bit_cnt=1, clear tick_cnt, go to DATA.
REQ-017 DATA: increment tick_cnt per tick; on tick_cnt=OVERSAMPLE-1, sample rx_s (mid-bit), shift it in, clear tick_cnt, increment bit_cnt.
REQ-018 Shifting SHALL be right-shift, new bit into MSB: shift <= {rx_s, shift[FRAME_BITS-1:1]}; the first received bit ends in [0].
REQ-019 On the tick that samples bit FRAME_BITS-1 (stop):
- data_parll SHALL load {rx_s, shift[FRAME_BITS-1:1]} on that same edge;
- frame_done SHALL assert for exactly the following clock cycle;
- state SHALL return to IDLE.
REQ-020 A stop bit sampled as 0 SHALL still complete the frame; framing error detection belongs downstream.
REQ-021 Parity SHALL NOT be checked here.
REQ-022 rx_en low in START or DATA SHALL force IDLE on the next edge, clear the counters, suppress frame_done, and keep data_parll unchanged.
REQ-023 A frame start is accepted on the first tick in IDLE with rx_s=0, so back-to-back frames with no idle gap SHALL both be received.
REQ-024 data_parll SHALL hold its value between frames.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While reset_n=0, independent of clock:
- state=IDLE; tick_cnt=0; bit_cnt=0;
- shift register and data_parll = all ones (11'h7FF);
- frame_done=0; busy=0; synchronizer flops=1.
REQ-027 A reset mid-frame SHALL discard the partial frame; the first frame_done after reset SHALL come only from a complete new frame.

Structure
REQ-028 Shared package uart_pkg SHALL hold:
- FRAME_BITS;
- bit-index constants START_IDX=0, PAR_IDX=9, STOP_IDX=10;
- the rx state enum type.
REQ-029 The synchronizer SHALL be a sub-module, rx_sync: 2 flops, reset value 1.
REQ-030 Implementation SHALL fit in 120-400 RTL lines.

Verification (OVERSAMPLE=16, sample_tick every 4th clock)
REQ-031 Send data 8'hA5, parity 0, stop 1 -> one frame_done pulse, data_parll=11'h54A, busy low afterwards.
REQ-032 rx_in low for 5 ticks, then high -> no frame_done, busy returns low, data_parll stays 11'h7FF.
REQ-033 Two back-to-back frames 8'h00 (parity 0) then 8'hFF (parity 0) -> two pulses, data_parll=11'h400 then 11'h5FE.
REQ-034 Frame with stop=0, data 8'h3C -> frame_done pulses, data_parll[10]=0, data_parll[8:1]=8'h3C.
REQ-035 rx_en dropped during data bit 4 -> busy falls the next cycle, no frame_done; a following full frame of 8'h81 yields 11'h502.
REQ-036 reset_n asserted mid-frame for 2 clocks -> all outputs at reset values immediately; a full frame sent afterwards decodes correctly.

Source files
------------

// File: rtl/uart_rx_sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART SIPO receiver: frame length,
//               bit positions inside a received frame, and the receiver
//               state type.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    // Bit positions inside data_parll
    localparam int START_IDX  = 0;
    localparam int PAR_IDX    = 9;
    localparam int STOP_IDX   = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sipo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sipo_if
// Description : Signal bundle between the serial line / baud generator and
//               the SIPO receiver, plus the parallel frame handed to the
//               DeFrame stage.
//   rx_in       serial line, idle high, LSB first
//   sample_tick one-clock pulse at OVERSAMPLE x baud
//   rx_en       receiver enable
//   data_parll  last complete frame ([0]=start, [8:1]=data, [9]=parity,
//               [10]=stop)
//   frame_done  one-clock pulse when data_parll takes a new frame
//   busy        receiver is not idle
// Modports    : master = receiver, slave = line driver / frame consumer
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_sipo_if #(
    parameter int FRAME_BITS = uart_pkg::FRAME_BITS
);
    logic                  rx_in;
    logic                  sample_tick;
    logic                  rx_en;
    logic [FRAME_BITS-1:0] data_parll;
    logic                  frame_done;
    logic                  busy;

    modport master (
        input  rx_in, sample_tick, rx_en,
        output data_parll, frame_done, busy
    );

    modport slave (
        output rx_in, sample_tick, rx_en,
        input  data_parll, frame_done, busy
    );

endinterface : uart_rx_sipo_if
`default_nettype wire

// File: rtl/uart_rx_sipo_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : rx_sync
// Description : Two-flop synchronizer for the asynchronous serial line.
//               Resets to 1 so a reset looks like an idle line and cannot
//               fake a start bit.
//   clock   rising-edge clock
//   reset_n asynchronous active-low reset
//   din     raw asynchronous input
//   dout    synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module rx_sync (
    input  wire  clock,
    input  wire  reset_n,
    input  wire  din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule : rx_sync
`default_nettype wire

// File: rtl/uart_rx_sipo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sipo
// Description : Oversampling UART receiver, serial-in / parallel-out. Finds
//               the start edge, confirms it at mid start bit, then samples
//               every following bit at its centre and shifts it in LSB
//               first. The whole raw frame (start, data, parity, stop) is
//               handed on unchecked.
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      uart_rx_sipo_if.master (rx_in, sample_tick, rx_en in;
//            data_parll, frame_done, busy out)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sipo
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int FRAME_BITS = uart_pkg::FRAME_BITS
) (
    input  wire            clock,
    input  wire            reset_n,
    uart_rx_sipo_if.master bus
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(FRAME_BITS + 1);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(FRAME_BITS - 1);
    localparam logic [FRAME_BITS-1:0] ALL_ONES = '1;

    logic                  rx_s;
    rx_state_t             state,      state_nxt;
    logic [TICK_W-1:0]     tick_cnt,   tick_nxt;
    logic [BIT_W-1:0]      bit_cnt,    bit_nxt;
    logic [FRAME_BITS-1:0] shift,      shift_nxt;
    logic [FRAME_BITS-1:0] frame,      frame_nxt;
    logic                  done,       done_nxt;
    logic                  busy_r;
    logic [FRAME_BITS-1:0] shift_in;

    rx_sync u_rx_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (bus.rx_in),
        .dout    (rx_s)
    );

    // Current shift register with the synchronized line bit entering at MSB
    assign shift_in = {rx_s, shift[FRAME_BITS-1:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= ALL_ONES;
            frame    <= ALL_ONES;
            done     <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            frame    <= frame_nxt;
            done     <= done_nxt;
            // Registered from the next state so busy tracks state exactly
            busy_r   <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        frame_nxt = frame;
        done_nxt  = 1'b0;

        if (!bus.rx_en) begin
            // Abandon any partial frame; frame and its strobe stay untouched
            state_nxt = IDLE;
            tick_nxt  = '0;
            bit_nxt   = '0;
        end else if (bus.sample_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        tick_nxt  = '0;
                        state_nxt = START;
                    end
                end
                START: begin
                    if (tick_cnt == HALF_LAST) begin
                        tick_nxt = '0;
                        if (rx_s) begin
                            // Line went back high before mid start bit: noise
                            state_nxt = IDLE;
                        end else begin
                            shift_nxt = shift_in;
                            bit_nxt   = BIT_W'(1);
                            state_nxt = DATA;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_nxt  = '0;
                        shift_nxt = shift_in;
                        if (bit_cnt == LAST_BIT) begin
                            // Stop bit: publish whatever it is, even 0
                            frame_nxt = shift_in;
                            done_nxt  = 1'b1;
                            bit_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            bit_nxt = bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        tick_nxt = tick_cnt + TICK_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                end
            endcase
        end
    end

    assign bus.data_parll = frame;
    assign bus.frame_done = done;
    assign bus.busy       = busy_r;

endmodule : uart_rx_sipo
`default_nettype wire

// File: tb/tb_uart_rx_sipo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_sipo
// Description : Self-checking bench for uart_rx_sipo (OVERSAMPLE=16,
//               sample_tick every 4th clock, so one bit = 64 clocks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sipo;

    localparam int BIT_CLKS = 64;

    logic clock;
    logic reset_n;

    uart_rx_sipo_if #(.FRAME_BITS(11)) bus ();

    uart_rx_sipo #(
        .OVERSAMPLE (16),
        .FRAME_BITS (11)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Baud generator stand-in: one tick every fourth clock
    initial begin
        int div;
        div = 0;
        bus.sample_tick = 1'b0;
        forever begin
            @(negedge clock);
            bus.sample_tick = (div == 3);
            div = (div + 1) % 4;
        end
    end

    // Capture every cycle frame_done is high; a stretched pulse shows up as
    // an extra entry.
    logic [10:0] got[$];
    always @(negedge clock) begin
        if (bus.frame_done === 1'b1)
            got.push_back(bus.data_parll);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a received frame is the line bits in time order, LSB first
    function automatic logic [10:0] frame_of(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic send_bit(input logic b);
        bus.rx_in = b;
        repeat (BIT_CLKS) @(negedge clock);
    endtask

    task automatic send_frame(input logic [10:0] f);
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        bus.rx_in = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        bus.rx_in = 1'b1;
        repeat (BIT_CLKS * n) @(negedge clock);
    endtask

    // One frame in, exactly one pulse out carrying the expected value
    task automatic frame_test(input string name, input logic [10:0] exp, input int gap);
        got.delete();
        send_frame(exp);
        idle_bits(gap);
        check({name, " pulses"}, got.size(), 1);
        check({name, " capture"}, got[0], exp);
        check({name, " data_parll"}, bus.data_parll, exp);
        check({name, " busy"}, bus.busy, 0);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  data;
        logic        par;
        logic        stop;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] f;
        int          gap;

        tbl[0] = '{"a5",   8'hA5, 1'b0, 1'b1, 11'h54A};
        tbl[1] = '{"stop0",8'h3C, 1'b0, 1'b0, 11'h078};
        tbl[2] = '{"zero", 8'h00, 1'b0, 1'b1, 11'h400};
        tbl[3] = '{"ones", 8'hFF, 1'b0, 1'b1, 11'h5FE};
        tbl[4] = '{"par1", 8'h81, 1'b1, 1'b1, 11'h702};

        reset_n    = 1'b0;
        bus.rx_in  = 1'b1;
        bus.rx_en  = 1'b1;
        repeat (4) @(negedge clock);
        check("reset data_parll", bus.data_parll, 11'h7FF);
        check("reset frame_done", bus.frame_done, 0);
        check("reset busy", bus.busy, 0);
        reset_n = 1'b1;
        idle_bits(1);

        // Short low pulse: start seen, rejected at mid start bit
        got.delete();
        bus.rx_in = 1'b0;
        repeat (16) @(negedge clock);
        check("glitch busy during", bus.busy, 1);
        repeat (4) @(negedge clock);
        idle_bits(2);
        check("glitch pulses", got.size(), 0);
        check("glitch busy after", bus.busy, 0);
        check("glitch data_parll", bus.data_parll, 11'h7FF);

        // Table of single frames
        for (int i = 0; i < 5; i++)
            frame_test(tbl[i].name, frame_of(tbl[i].data, tbl[i].par, tbl[i].stop), 1);
        for (int i = 0; i < 5; i++)
            check({tbl[i].name, " table"}, frame_of(tbl[i].data, tbl[i].par, tbl[i].stop), tbl[i].exp);

        // Back-to-back frames, no idle gap
        got.delete();
        send_frame(11'h400);
        send_frame(11'h5FE);
        idle_bits(1);
        check("b2b pulses", got.size(), 2);
        check("b2b first", got[0], 11'h400);
        check("b2b second", got[1], 11'h5FE);
        check("b2b busy", bus.busy, 0);

        // rx_en dropped in the middle of data bit 4
        got.delete();
        f = frame_of(8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(f[i]);
        bus.rx_in = f[5];
        repeat (BIT_CLKS / 2) @(negedge clock);
        check("abort busy before", bus.busy, 1);
        bus.rx_en = 1'b0;
        @(negedge clock);
        check("abort busy next cycle", bus.busy, 0);
        repeat (BIT_CLKS / 2) @(negedge clock);
        for (int i = 6; i < 11; i++) send_bit(f[i]);
        idle_bits(1);
        check("abort pulses", got.size(), 0);
        check("abort data_parll", bus.data_parll, 11'h5FE);
        bus.rx_en = 1'b1;
        frame_test("after abort", 11'h502, 1);

        // Reset in the middle of a frame
        got.delete();
        f = frame_of(8'hC3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(f[i]);
        reset_n = 1'b0;
        #1;
        check("midreset data_parll", bus.data_parll, 11'h7FF);
        check("midreset frame_done", bus.frame_done, 0);
        check("midreset busy", bus.busy, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        idle_bits(8);
        check("midreset pulses", got.size(), 0);
        frame_test("after reset", frame_of(8'hC3, 1'b0, 1'b1), 1);

        // Random frames against the frame model
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            logic       p;
            logic       s;
            d   = 8'($urandom);
            p   = 1'($urandom);
            s   = ($urandom_range(0, 3) != 0);
            gap = s ? $urandom_range(0, 2) : $urandom_range(1, 2);
            got.delete();
            send_frame(frame_of(d, p, s));
            idle_bits(gap);
            check("rand pulses", got.size(), 1);
            check("rand capture", got[0], frame_of(d, p, s));
        end
        idle_bits(1);
        check("final busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_sipo
`default_nettype wire
